mpu_matrix_loader: RTL and testbench

//   Write side of the MPU matrix bus. Assembles a square matrix (1x1..5x5) from a

---
 rtl/mpu_matrix_loader.sv | 96 +++++++++
 tb/tb_mpu_matrix_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_matrix_loader.sv
// Assembles a 1x1..DIMxDIM signed matrix from a serial element stream and holds it until the consumer acks; matrix_valid rises one cycle after the last transfer.
// Backpressure: in_ready is high only while loading, and the held matrix stays frozen until matrix_ack.
// Optional MPU_LOADER_TRANSPOSE_EN: the stream is column-major, so each element is written at (col,row).
module mpu_matrix_loader #(
   parameter int DIM = 5,
   parameter int EW  = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [7:0]              size_in,
   input  logic                    in_valid,
   input  logic [EW-1:0]           in_data,
   output logic                    in_ready,
   output logic [0:DIM*DIM*EW-1]   matrix_out,
   output logic [7:0]              size_out,
   output logic                    matrix_valid,
   input  logic                    matrix_ack,
   output logic                    error
);

   localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic signed [7:0] DIM_S = 8'(DIM);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] row, col, last;
   logic          size_ok, xfer, last_xfer, accept, bad_start;

   // Size code is signed: 0, negatives and anything above DIM are rejected.
   assign size_ok   = ($signed(size_in) > 8'sd0) && ($signed(size_in) <= DIM_S);
   assign last      = size_out[CW-1:0] - CW'(1);
   assign in_ready  = (state == S_LOAD);
   assign xfer      = in_valid & in_ready;
   assign last_xfer = xfer && (row == last) && (col == last);
   assign matrix_valid = (state == S_HOLD);

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      bad_start = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (size_ok) begin
                  accept    = 1'b1;
                  state_nxt = S_LOAD;
               end else begin
                  bad_start = 1'b1;
               end
            end
         end
         S_LOAD: if (last_xfer) state_nxt = S_HOLD;
         // Ack wins over a coincident start; start is only sampled in IDLE.
         S_HOLD: if (matrix_ack) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         matrix_out <= '0;
         size_out   <= '0;
         row        <= '0;
         col        <= '0;
         error      <= 1'b0;
      end else begin
         error <= bad_start;
         if (accept) begin
            size_out   <= size_in;
            matrix_out <= '0;
            row        <= '0;
            col        <= '0;
         end else if (xfer) begin
`ifdef MPU_LOADER_TRANSPOSE_EN
            matrix_out[EW*(int'(row) + DIM*int'(col)) +: EW] <= in_data;
`else
            matrix_out[EW*(int'(col) + DIM*int'(row)) +: EW] <= in_data;
`endif
            if (col == last) begin
               col <= '0;
               row <= row + CW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Randomised bench for mpu_matrix_loader against a row/column arithmetic reference model.
module tb_mpu_matrix_loader;

   logic         clock, reset, start, in_valid, in_ready, matrix_valid, matrix_ack, error;
   logic [7:0]   size_in, in_data, size_out;
   logic [0:199] matrix_out;

   int checks = 0;
   int errors = 0;

   logic [7:0] stream_q[$];
   logic [7:0] exp_m[5][5];
   logic [7:0] exp_size;

   mpu_matrix_loader #(.DIM(5), .EW(8)) dut (
      .clock(clock), .reset(reset), .start(start), .size_in(size_in),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .matrix_out(matrix_out), .size_out(size_out), .matrix_valid(matrix_valid),
      .matrix_ack(matrix_ack), .error(error)
   );

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   function automatic logic [7:0] elem(int r, int c);
      return matrix_out[8*(c + 5*r) +: 8];
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Element k of an n x n stream belongs at row k/n, column k%n (swapped when transposing).
   task automatic set_model(int n);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) exp_m[r][c] = 8'd0;
      for (int k = 0; k < n*n; k++) begin
`ifdef MPU_LOADER_TRANSPOSE_EN
         exp_m[k % n][k / n] = stream_q[k];
`else
         exp_m[k / n][k % n] = stream_q[k];
`endif
      end
      exp_size = 8'(n);
   endtask

   // mode 0: no stalls, 1: in_valid low every 3rd cycle, 2: random stalls
   task automatic do_load(int n, int mode);
      int idx = 0;
      int cyc = 0;
      logic v;
      start = 1; size_in = 8'(n);
      tick();
      start = 0;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b want 1", in_ready); end
      while (idx < n*n && cyc < 400) begin
         case (mode)
            0: v = 1'b1;
            1: v = ((cyc % 3) != 2);
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         checks++;
         if (matrix_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL load_busy valid=%b ready=%b want 0/1 at idx %0d", matrix_valid, in_ready, idx);
         end
         in_valid = v; in_data = stream_q[idx];
         tick();
         if (v) idx++;
         cyc++;
      end
      in_valid = 0;
      if (idx < n*n) begin errors++; $display("FAIL load_timeout got %0d transfers want %0d", idx, n*n); end
      checks++;
      if (matrix_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL load_done valid=%b ready=%b want 1/0", matrix_valid, in_ready);
      end
      set_model(n);
   endtask

   task automatic test_reset();
      reset = 1; start = 0; size_in = 0; in_valid = 0; in_data = 0; matrix_ack = 0;
      tick(); tick();
      reset = 0;
      checks++;
      if (in_ready !== 0 || matrix_valid !== 0 || error !== 0 || size_out !== 0 || matrix_out !== '0) begin
         errors++; $display("FAIL reset_state ready=%b valid=%b err=%b size=%0d mat_nz=%b want all 0",
                            in_ready, matrix_valid, error, size_out, |matrix_out);
      end
   endtask

   task automatic test_size2();
      stream_q = '{8'd1, 8'd2, 8'd3, 8'd4};
      do_load(2, 0);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) begin
            checks++;
            if (elem(r, c) !== exp_m[r][c]) begin
               errors++; $display("FAIL size2_elem(%0d,%0d) got %0d want %0d", r, c, elem(r, c), exp_m[r][c]);
            end
         end
      checks++;
      if (size_out !== 8'd2) begin errors++; $display("FAIL size2_size got %0d want 2", size_out); end
      matrix_ack = 1; tick(); matrix_ack = 0;
      checks++;
      if (matrix_valid !== 0) begin errors++; $display("FAIL size2_ack valid=%b want 0", matrix_valid); end
   endtask

   task automatic test_size5_stall();
      int hold_cycles;
      stream_q.delete();
      for (int k = 0; k < 25; k++) stream_q.push_back(8'(k + 1));
      do_load(5, 1);
      hold_cycles = $urandom_range(2, 6);
      for (int i = 0; i < hold_cycles; i++) begin
         start = ($urandom_range(0, 1) == 1); size_in = 8'd2;
         in_valid = 1; in_data = 8'hAA;
         tick();
         checks++;
         if (matrix_valid !== 1 || in_ready !== 0) begin
            errors++; $display("FAIL hold_stable valid=%b ready=%b want 1/0", matrix_valid, in_ready);
         end
      end
      start = 0; in_valid = 0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) begin
            checks++;
            if (elem(r, c) !== exp_m[r][c]) begin
               errors++; $display("FAIL size5_elem(%0d,%0d) got %0d want %0d", r, c, elem(r, c), exp_m[r][c]);
            end
         end
      matrix_ack = 1; tick(); matrix_ack = 0;
      checks++;
      if (matrix_valid !== 0 || in_ready !== 0 || elem(4, 4) !== exp_m[4][4] || size_out !== 8'd5) begin
         errors++; $display("FAIL size5_ack valid=%b ready=%b e44=%0d size=%0d want 0/0/%0d/5",
                            matrix_valid, in_ready, elem(4, 4), size_out, exp_m[4][4]);
      end
   endtask

   task automatic test_reset_mid_load();
      stream_q = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      start = 1; size_in = 8'd3; tick(); start = 0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1; in_data = stream_q[k]; tick();
      end
      reset = 1; start = 1; in_data = 8'h55;
      tick();
      reset = 0; start = 0; in_valid = 0;
      checks++;
      if (in_ready !== 0 || matrix_valid !== 0 || error !== 0 || size_out !== 0 || matrix_out !== '0) begin
         errors++; $display("FAIL midload_reset ready=%b valid=%b err=%b size=%0d mat_nz=%b want all 0",
                            in_ready, matrix_valid, error, size_out, |matrix_out);
      end
      in_valid = 1; tick(); in_valid = 0;
      checks++;
      if (in_ready !== 0 || matrix_out !== '0) begin
         errors++; $display("FAIL midload_idle ready=%b mat_nz=%b want 0/0", in_ready, |matrix_out);
      end
      set_model(0);
      exp_size = 8'd0;
   endtask

   task automatic test_illegal();
      logic [7:0] bad[5];
      bad[0] = 8'd0; bad[1] = 8'd6; bad[2] = 8'hFF;
      bad[3] = 8'($urandom_range(6, 127)); bad[4] = 8'($urandom_range(128, 255));
      // Preload a known matrix so "unchanged" is meaningful.
      stream_q = '{8'h81, 8'h7F, 8'h00, 8'hC3};
      do_load(2, 2);
      matrix_ack = 1; tick(); matrix_ack = 0;
      for (int i = 0; i < 5; i++) begin
         start = 1; size_in = bad[i]; tick(); start = 0;
         checks++;
         if (error !== 1 || in_ready !== 0) begin
            errors++; $display("FAIL illegal_pulse size_in=%0d err=%b ready=%b want 1/0", bad[i], error, in_ready);
         end
         in_valid = 1; tick(); in_valid = 0;
         checks++;
         if (error !== 0 || in_ready !== 0 || size_out !== exp_size) begin
            errors++; $display("FAIL illegal_after size_in=%0d err=%b ready=%b size=%0d want 0/0/%0d",
                               bad[i], error, in_ready, size_out, exp_size);
         end
      end
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) begin
            checks++;
            if (elem(r, c) !== exp_m[r][c]) begin
               errors++; $display("FAIL illegal_keep(%0d,%0d) got %0d want %0d", r, c, elem(r, c), exp_m[r][c]);
            end
         end
   endtask

   task automatic test_hold_start_ack();
      stream_q = '{8'd11, 8'd22, 8'd33, 8'd44};
      do_load(2, 0);
      start = 1; size_in = 8'd3; matrix_ack = 1;
      tick();
      matrix_ack = 0; size_in = 8'd1;
      checks++;
      if (matrix_valid !== 0 || in_ready !== 0) begin
         errors++; $display("FAIL hold_ack_start valid=%b ready=%b want 0/0", matrix_valid, in_ready);
      end
      stream_q = '{8'hF9};
      do_load(1, 0);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) begin
            checks++;
            if (elem(r, c) !== exp_m[r][c]) begin
               errors++; $display("FAIL one_elem(%0d,%0d) got %0d want %0d", r, c, elem(r, c), exp_m[r][c]);
            end
         end
      checks++;
      if ($signed(matrix_out[0 +: 8]) !== -8'sd7 || size_out !== 8'd1) begin
         errors++; $display("FAIL one_value got %0d size %0d want -7 size 1", $signed(matrix_out[0 +: 8]), size_out);
      end
      matrix_ack = 1; tick(); matrix_ack = 0;
   endtask

   task automatic test_back_to_back();
      int n;
      int bad_cnt;
      for (int t = 0; t < 12; t++) begin
         n = $urandom_range(1, 5);
         stream_q.delete();
         for (int k = 0; k < n*n; k++) stream_q.push_back(8'($urandom));
         do_load(n, 2);
         repeat ($urandom_range(0, 3)) tick();
         bad_cnt = 0;
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
               if (elem(r, c) !== exp_m[r][c]) bad_cnt++;
         checks++;
         if (bad_cnt != 0 || size_out !== exp_size || matrix_valid !== 1) begin
            errors++; $display("FAIL random_load n=%0d bad_elems=%0d size=%0d valid=%b want 0/%0d/1",
                               n, bad_cnt, size_out, matrix_valid, exp_size);
         end
         matrix_ack = 1; tick(); matrix_ack = 0;
         checks++;
         if (matrix_valid !== 0) begin errors++; $display("FAIL random_ack valid=%b want 0", matrix_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_size2();
      test_size5_stall();
      test_reset_mid_load();
      test_illegal();
      test_hold_start_ack();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
